// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of a small synchronous FIFO
// among several valid/ready producers, with bounded bursts per grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    input  logic                      fifo_empty,
    input  logic                      fifo_r_en,
    output logic                      fifo_w_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_nxt;
    logic [IDX_W-1:0]   last, last_nxt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   pick;
    logic               can_write;
    logic               release_grant;

    // First valid requester strictly after 'start' in circular order; 'start' itself is checked last.
    function automatic logic [IDX_W-1:0] pick_next(input logic [IDX_W-1:0] start,
                                                   input logic [NUM_REQ-1:0] valid);
        logic [IDX_W-1:0] result;
        logic [IDX_W-1:0] cand;
        logic             found;
        int               idx;
        result = start;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(start) + k) % NUM_REQ;
            cand = IDX_W'(idx);
            if (!found && valid[cand]) begin
                result = cand;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            beat_cnt <= '0;
            last     <= IDX_W'(NUM_REQ - 1);
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_nxt;
            last     <= last_nxt;
        end
    end

    // A stalled grant (can_write low) is frozen: no beat counting and no release.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        beat_nxt      = beat_cnt;
        last_nxt      = last;
        owner         = '0;
        pick          = '0;
        release_grant = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                owner = IDX_W'(i);
            end
        end
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    pick            = pick_next(last, req_valid);
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    beat_nxt        = '0;
                    state_nxt       = GRANT;
                end
            end
            GRANT: begin
                if (can_write) begin
                    release_grant = !req_valid[owner] ||
                                    (fifo_w_en && (beat_cnt == CNT_W'(MAX_BURST - 1)));
                    if (release_grant) begin
                        last_nxt = owner;
                        beat_nxt = '0;
                        if (|req_valid) begin
                            pick            = pick_next(owner, req_valid);
                            grant_nxt       = '0;
                            grant_nxt[pick] = 1'b1;
                        end else begin
                            grant_nxt = '0;
                            state_nxt = IDLE;
                        end
                    end else if (fifo_w_en) begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                beat_nxt  = '0;
            end
        endcase
    end

    // The FIFO services a read before a write, so a write in a non-empty read cycle would be lost.
    always_comb begin
        can_write    = !fifo_full && !(fifo_r_en && !fifo_empty);
        req_ready    = grant & {NUM_REQ{can_write}};
        fifo_w_en    = |(req_valid & req_ready);
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                fifo_data_in = fifo_data_in | req_data[i*DATA_W +: DATA_W];
            end
        end
        busy = (state == GRANT);
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: an 8-deep FIFO occupancy model plus
// producers whose beats carry (producer+1)<<4 | beat-number.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_r_en;
    logic                      fifo_w_en;
    logic [DATA_W-1:0]         fifo_data_in;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;

    int         passed      = 0;
    int         total       = 0;
    int         lost_writes = 0;
    bit         auto_drain  = 1'b0;
    logic [3:0] fifo_count  = 4'd0;
    logic [7:0] seq [NUM_REQ] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] wr_log [$];
    logic [7:0] exp_log [14] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22,
                                 8'h23, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    logic [3:0] exp_grant [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                  4'b0010, 4'b0010, 4'b0010, 4'b0100};
    int         base;
    int         n;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_r_en   (fifo_r_en),
        .fifo_w_en   (fifo_w_en),
        .fifo_data_in(fifo_data_in),
        .grant       (grant),
        .busy        (busy)
    );

    assign fifo_full  = (fifo_count == 4'd8);
    assign fifo_empty = (fifo_count == 4'd0);

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = 8'((i + 1) * 16) + seq[i];
        end
    end

    // Read-first FIFO occupancy model; a write in a read cycle or into a full FIFO is lost.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                seq[i] <= seq[i] + 8'd1;
            end
        end
        if (fifo_r_en && fifo_count != 4'd0) begin
            fifo_count <= fifo_count - 4'd1;
            if (fifo_w_en) lost_writes++;
        end else if (fifo_w_en && fifo_count != 4'd8) begin
            fifo_count <= fifo_count + 4'd1;
            wr_log.push_back(fifo_data_in);
        end else if (fifo_w_en) begin
            lost_writes++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic next_cycle();
        @(negedge clk);
        if (auto_drain) fifo_r_en = (fifo_count >= 4'd6);
    endtask

    task automatic wait_grant_change(input logic [3:0] prev, input string tag);
        int cnt;
        cnt = 0;
        while (grant === prev && cnt < 60) begin
            next_cycle();
            #1;
            cnt++;
        end
        check_output(tag, 32'(cnt >= 60), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'hF;
        fifo_r_en = 1'b0;

        // Reset with all producers requesting.
        next_cycle();
        #1;
        check_output("rst_grant", 32'(grant), 32'h0);
        check_output("rst_ready", 32'(req_ready), 32'h0);
        check_output("rst_w_en", 32'(fifo_w_en), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_data", 32'(fifo_data_in), 32'h0);
        next_cycle();
        reset_n = 1'b1;
        #1;
        check_output("rel_grant_idle", 32'(grant), 32'h0);

        // Round-robin bursts of four until the FIFO fills.
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            #1;
            check_output($sformatf("rr_grant_%0d", c), 32'(grant), 32'(exp_grant[c]));
            check_output($sformatf("rr_w_en_%0d", c), 32'(fifo_w_en), 32'(c < 8));
            if (c < 8) check_output($sformatf("rr_data_%0d", c), 32'(fifo_data_in), 32'(exp_log[c]));
        end
        check_output("rr_busy", 32'(busy), 32'h1);

        // Full FIFO holds the grant; a single consumer read lets exactly one beat in.
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            #1;
            check_output("full_grant", 32'(grant), 32'h4);
            check_output("full_ready", 32'(req_ready), 32'h0);
        end
        next_cycle();
        fifo_r_en = 1'b1;
        #1;
        check_output("full_read_w_en", 32'(fifo_w_en), 32'h0);
        next_cycle();
        fifo_r_en = 1'b0;
        #1;
        check_output("full_one_ready", 32'(req_ready), 32'h4);
        check_output("full_one_data", 32'(fifo_data_in), 32'h30);
        next_cycle();
        #1;
        check_output("full_again_w_en", 32'(fifo_w_en), 32'h0);
        check_output("full_log_size", 32'(wr_log.size()), 32'd9);

        // Reads into a non-empty FIFO block writes.
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            fifo_r_en = 1'b1;
            #1;
            check_output($sformatf("coll_w_en_%0d", c), 32'(fifo_w_en), 32'h0);
        end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            fifo_r_en = 1'b0;
            #1;
            check_output($sformatf("coll_after_%0d", c), 32'(fifo_data_in), 32'(exp_log[9 + c]));
            check_output($sformatf("coll_w_en_after_%0d", c), 32'(fifo_w_en), 32'h1);
        end
        next_cycle();
        #1;
        check_output("burst_rotate_3", 32'(grant), 32'h8);
        check_output("log_size_12", 32'(wr_log.size()), 32'd12);
        for (int i = 0; i < 12 && i < wr_log.size(); i++) begin
            check_output($sformatf("log_%0d", i), 32'(wr_log[i]), 32'(exp_log[i]));
        end

        // Owner drops valid with nobody else requesting: back to IDLE, then drain.
        req_valid = 4'h0;
        next_cycle();
        #1;
        check_output("idle_grant", 32'(grant), 32'h0);
        check_output("idle_busy", 32'(busy), 32'h0);
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            fifo_r_en = 1'b1;
        end

        // Early release: requester 2 sends two beats then drops valid.
        next_cycle();
        fifo_r_en = 1'b0;
        req_valid = 4'b0100;
        next_cycle();
        #1;
        check_output("early_grant2", 32'(grant), 32'h4);
        check_output("early_data0", 32'(fifo_data_in), 32'h34);
        req_valid = 4'b1100;
        next_cycle();
        #1;
        check_output("early_data1", 32'(fifo_data_in), 32'h35);
        next_cycle();
        req_valid = 4'b1000;
        #1;
        check_output("early_drop_w_en", 32'(fifo_w_en), 32'h0);
        check_output("early_drop_ready", 32'(req_ready), 32'h4);
        next_cycle();
        #1;
        check_output("early_grant3", 32'(grant), 32'h8);
        check_output("early_data3", 32'(fifo_data_in), 32'h40);
        check_output("early_log_12", 32'(wr_log[12]), 32'(exp_log[12]));
        check_output("early_log_13", 32'(wr_log[13]), 32'(exp_log[13]));

        // Requester 2 re-raises and waits behind 3, 0, 1.
        req_valid  = 4'hF;
        auto_drain = 1'b1;
        wait_grant_change(4'b1000, "wait_after_3");
        check_output("order_0", 32'(grant), 32'h1);
        check_output("order_0_data", 32'(fifo_data_in), 32'h14);
        wait_grant_change(4'b0001, "wait_after_0");
        check_output("order_1", 32'(grant), 32'h2);
        check_output("order_1_data", 32'(fifo_data_in), 32'h24);
        wait_grant_change(4'b0010, "wait_after_1");
        check_output("order_2", 32'(grant), 32'h4);
        check_output("order_2_data", 32'(fifo_data_in), 32'h36);

        // Reset in the middle of requester 2's burst, after two beats.
        base = wr_log.size();
        n    = 0;
        while (wr_log.size() < base + 2 && n < 60) begin
            next_cycle();
            #1;
            n++;
        end
        check_output("mid_burst_timeout", 32'(n >= 60), 32'd0);
        reset_n = 1'b0;
        #1;
        check_output("mid_rst_grant", 32'(grant), 32'h0);
        check_output("mid_rst_w_en", 32'(fifo_w_en), 32'h0);
        check_output("mid_rst_busy", 32'(busy), 32'h0);
        base = wr_log.size();
        for (int c = 0; c < 3; c++) next_cycle();
        #1;
        check_output("mid_rst_no_writes", 32'(wr_log.size()), 32'(base));
        reset_n = 1'b1;
        next_cycle();
        #1;
        check_output("mid_rst_restart", 32'(grant), 32'h1);
        check_output("mid_rst_restart_data", 32'(fifo_data_in), 32'h18);
        check_output("lost_writes", 32'(lost_writes), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
